// File: rtl/led_sched_pkg.sv
// rtl/led_sched_pkg.sv - shared types and helpers for the LED pattern scheduler
// Purpose: scheduler state enum, prescaler divide calculation and its sanity check.
// Ports: none (package).
package led_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } sched_state_e;

  // Clock cycles per pattern bit.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // A divide below 2 would leave the tick permanently high.
  function automatic bit div_ok(input int div);
    return div >= 2;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - bit-rate prescaler for the LED pattern scheduler
// Purpose: counts 0..DIV-1 and pulses tick on the last count.
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset
//   clr   - restart the count at 0 on the next cycle
//   tick  - one-cycle pulse while the count is DIV-1
module led_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == CNT_W'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_scheduler.sv
// rtl/led_pattern_scheduler.sv - round-robin sharing of one status LED between requesters
// Purpose: grants the LED to one requester at a time, plays its latched pattern
//   LSB-first for HOLD_REPS repetitions, then blanks for one tick before re-arbitrating.
// Ports:
//   clk, rst_n - clock and synchronous active-low reset
//   req        - level request per requester
//   pattern    - requester i pattern at [i*PAT_W +: PAT_W]
//   grant      - one-hot current owner, zero when unowned
//   done       - one-cycle pulse when a grant ends
//   done_id    - finished owner index, valid with done
//   aborted    - grant ended by request withdrawal, valid with done
//   busy       - high while playing or blanking
//   LED        - LED drive, active high
module led_pattern_scheduler
  import led_sched_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 8,
  parameter int N_REQ     = 4,
  parameter int PAT_W     = 8,
  parameter int HOLD_REPS = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*PAT_W-1:0]   pattern,
  output logic [N_REQ-1:0]         grant,
  output logic                     done,
  output logic [$clog2(N_REQ)-1:0] done_id,
  output logic                     aborted,
  output logic                     busy,
  output logic                     LED
);

  localparam int DIV   = calc_div(CLK_HZ, TICK_HZ);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int REP_W = (HOLD_REPS > 1) ? $clog2(HOLD_REPS) : 1;

  if (!div_ok(DIV)) begin : g_div_chk
    $error("led_pattern_scheduler: CLK_HZ/TICK_HZ must be >= 2");
  end

  sched_state_e     state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [ID_W-1:0]  last_q, last_d;      // also the current owner while playing
  logic             done_q, done_d;
  logic [ID_W-1:0]  done_id_q, done_id_d;
  logic             aborted_q, aborted_d;
  logic             clr;
  logic             tick;
  logic [ID_W-1:0]  winner;

  led_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

  // First set request after the previous winner, wrapping. Walking the offsets
  // from farthest to nearest lets the nearest hit overwrite the others.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [ID_W-1:0]  last);
    logic [ID_W-1:0] w;
    logic [ID_W-1:0] cand;
    w = last;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(last) + k) % N_REQ);
      if (r[cand]) w = cand;
    end
    return w;
  endfunction

  assign winner = rr_pick(req, last_q);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    pat_d     = pat_q;
    bit_d     = bit_q;
    rep_d     = rep_q;
    last_d    = last_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    aborted_d = aborted_q;
    clr       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          pat_d           = pattern[int'(winner)*PAT_W +: PAT_W];
          bit_d           = '0;
          rep_d           = '0;
          last_d          = winner;
          state_d         = PLAY;
          clr             = 1'b1;
        end
      end
      PLAY: begin
        if (tick) begin
          // Withdrawal is only observed on tick boundaries and wins over completion.
          if (!req[last_q] ||
              (bit_q == BIT_W'(PAT_W - 1) && rep_q == REP_W'(HOLD_REPS - 1))) begin
            state_d   = GAP;
            grant_d   = '0;
            done_d    = 1'b1;
            done_id_d = last_q;
            aborted_d = !req[last_q];
            clr       = 1'b1;
          end else if (bit_q == BIT_W'(PAT_W - 1)) begin
            bit_d = '0;
            rep_d = rep_q + 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      pat_q     <= '0;
      bit_q     <= '0;
      rep_q     <= '0;
      last_q    <= ID_W'(N_REQ - 1);
      done_q    <= 1'b0;
      done_id_q <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      pat_q     <= pat_d;
      bit_q     <= bit_d;
      rep_q     <= rep_d;
      last_q    <= last_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      aborted_q <= aborted_d;
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign aborted = aborted_q;
  assign busy    = (state_q != IDLE);
  assign LED     = (state_q == PLAY) && pat_q[bit_q];

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// tb/tb_led_pattern_scheduler.sv - self-checking bench for led_pattern_scheduler
module tb_led_pattern_scheduler;

  localparam int CLK_HZ    = 16;
  localparam int TICK_HZ   = 4;
  localparam int N_REQ     = 4;
  localparam int PAT_W     = 4;
  localparam int HOLD_REPS = 2;
  localparam int DIV       = CLK_HZ / TICK_HZ;
  localparam int TOTAL     = PAT_W * HOLD_REPS * DIV;
  localparam int ID_W      = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*PAT_W-1:0] pattern;
  logic [N_REQ-1:0]       grant;
  logic                   done;
  logic [ID_W-1:0]        done_id;
  logic                   aborted;
  logic                   busy;
  logic                   LED;

  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 = none), cycles since grant, gap cycles left.
  int             m_owner;
  int             m_t;
  int             m_gap;
  int             m_last;
  logic [PAT_W-1:0] m_pat;
  logic           m_done;
  int             m_done_id;
  logic           m_ab;

  always #5 clk = ~clk;

  led_pattern_scheduler #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .N_REQ(N_REQ),
    .PAT_W(PAT_W), .HOLD_REPS(HOLD_REPS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .pattern(pattern),
    .grant(grant), .done(done), .done_id(done_id), .aborted(aborted),
    .busy(busy), .LED(LED)
  );

  task automatic model_step();
    int c;
    if (!rst_n) begin
      m_owner = -1; m_gap = 0; m_last = N_REQ - 1;
      m_done = 1'b0; m_done_id = 0; m_ab = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_owner >= 0) begin
        if ((m_t % DIV == DIV - 1) && (!req[m_owner] || m_t == TOTAL - 1)) begin
          m_done = 1'b1; m_done_id = m_owner; m_ab = !req[m_owner];
          m_owner = -1; m_gap = DIV;
        end else begin
          m_t++;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (req != '0) begin
        for (int k = 1; k <= N_REQ; k++) begin
          c = (m_last + k) % N_REQ;
          if (req[c]) begin
            m_owner = c;
            break;
          end
        end
        m_last = m_owner;
        m_t    = 0;
        m_pat  = pattern[m_owner*PAT_W +: PAT_W];
      end
    end
  endtask

  function automatic logic [9:0] exp_vec();
    logic [N_REQ-1:0] g;
    logic             l;
    g = (m_owner >= 0) ? (N_REQ'(1) << m_owner) : '0;
    l = (m_owner >= 0) ? m_pat[(m_t / DIV) % PAT_W] : 1'b0;
    return {g, l, (m_owner >= 0 || m_gap > 0), m_done,
            m_done ? ID_W'(m_done_id) : 2'b00, m_done ? m_ab : 1'b0};
  endfunction

  function automatic logic [9:0] obs_vec();
    return {grant, LED, busy, done, done ? done_id : 2'b00, done ? aborted : 1'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; pattern = 16'hFFFF;
    step(); step();
    checks++;
    if ({grant, LED, busy, done, done_id, aborted} !== 9'b0) begin
      errors++;
      $display("FAIL reset_state: got grant=%b led=%b busy=%b done=%b id=%0d ab=%b, want all zero",
               grant, LED, busy, done, done_id, aborted);
    end
    rst_n = 1'b1; req = '0;
    step();
  endtask

  task automatic test_single();
    logic [7:0] seq;
    seq = 8'b1011_1011;
    do_reset();
    pattern = {12'h000, 4'b1011};
    req = 4'b0001;
    step();
    checks++;
    if (grant !== 4'b0001) begin
      errors++; $display("FAIL single_grant: got %b want 0001", grant);
    end
    for (int i = 0; i < TOTAL; i++) begin
      checks++;
      if (LED !== seq[i / DIV] || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single_led cyc=%0d: got led=%b obs=%b, want led=%b exp=%b",
                 i, LED, obs_vec(), seq[i / DIV], exp_vec());
      end
      step();
    end
    checks++;
    if ({done, done_id, aborted, grant} !== {1'b1, 2'd0, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL single_done: got done=%b id=%0d ab=%b grant=%b, want 1 0 0 0000",
               done, done_id, aborted, grant);
    end
    for (int i = 0; i < DIV + 2; i++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL single_gap cyc=%0d: got %b want %b", i, obs_vec(), exp_vec());
      end
      step();
    end
    checks++;
    if (grant !== 4'b0001) begin
      errors++; $display("FAIL single_regrant: got %b want 0001", grant);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    logic [N_REQ-1:0] prev;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    pattern = 16'($urandom);
    req = 4'b1111;
    prev = '0;
    for (int i = 0; i < 5 * (TOTAL + DIV + 1); i++) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL rr_cycle cyc=%0d: got %b want %b", i, obs_vec(), exp_vec());
      end
      if (prev == '0 && grant != '0) begin
        for (int b = 0; b < N_REQ; b++) if (grant[b]) order.push_back(b);
      end
      prev = grant;
    end
    checks++;
    if (order.size() < 5) begin
      errors++; $display("FAIL rr_count: got %0d grants want 5", order.size());
    end else begin
      for (int j = 0; j < 5; j++) begin
        checks++;
        if (order[j] !== exp_order[j]) begin
          errors++; $display("FAIL rr_order idx=%0d: got %0d want %0d", j, order[j], exp_order[j]);
        end
      end
    end
  endtask

  task automatic test_abort();
    do_reset();
    pattern = 16'($urandom);
    req = 4'b0010;
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL abort_play cyc=%0d: got %b want %b", i, obs_vec(), exp_vec());
      end
      step();
    end
    req = 4'b0000;
    step(); step();
    checks++;
    if (done !== 1'b0 || grant !== 4'b0010) begin
      errors++; $display("FAIL abort_early: got done=%b grant=%b want 0 0010", done, grant);
    end
    step();
    checks++;
    if ({done, done_id, aborted, grant, LED} !== {1'b1, 2'd1, 1'b1, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL abort_done: got done=%b id=%0d ab=%b grant=%b led=%b, want 1 1 1 0000 0",
               done, done_id, aborted, grant, LED);
    end
  endtask

  task automatic test_pattern_change();
    int cnt1, cnt2;
    cnt1 = 0; cnt2 = 0;
    do_reset();
    pattern = {12'h000, 4'b1011};
    req = 4'b0001;
    step();
    for (int i = 0; i < TOTAL; i++) begin
      cnt1 += int'(LED);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL patchg_first cyc=%0d: got %b want %b", i, obs_vec(), exp_vec());
      end
      if (i == 10) pattern = 16'h0000;
      step();
    end
    repeat (DIV + 1) step();
    for (int i = 0; i < TOTAL; i++) begin
      cnt2 += int'(LED);
      step();
    end
    checks++;
    if (cnt1 !== 24 || cnt2 !== 0) begin
      errors++; $display("FAIL patchg_count: got %0d/%0d lit cycles want 24/0", cnt1, cnt2);
    end
  endtask

  task automatic test_late_arrival();
    do_reset();
    pattern = 16'($urandom);
    req = 4'b0001;
    step();
    repeat (TOTAL) step();
    step();
    req = 4'b1001;
    step(); step(); step();
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL late_idle: got grant=%b busy=%b want 0000 0", grant, busy);
    end
    step();
    checks++;
    if (grant !== 4'b1000) begin
      errors++; $display("FAIL late_grant: got %b want 1000", grant);
    end
  endtask

  task automatic test_reset_mid_play();
    do_reset();
    pattern = 16'hFFFF;
    req = 4'b0100;
    step();
    repeat (9) step();
    rst_n = 1'b0;
    step();
    checks++;
    if (grant !== 4'b0000 || LED !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset: got grant=%b led=%b busy=%b want 0000 0 0", grant, LED, busy);
    end
    rst_n = 1'b1;
    req = 4'b1100;
    step();
    checks++;
    if (grant !== 4'b0100) begin
      errors++; $display("FAIL midreset_last: got %b want 0100", grant);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) req = 4'($urandom);
      if ($urandom_range(0, 7) == 0) pattern = 16'($urandom);
      rst_n = ($urandom_range(0, 299) != 0);
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cyc=%0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; pattern = '0;
    m_owner = -1; m_t = 0; m_gap = 0; m_last = N_REQ - 1;
    m_pat = '0; m_done = 1'b0; m_done_id = 0; m_ab = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_abort();
    test_pattern_change();
    test_late_arrival();
    test_reset_mid_play();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
